// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame states, parity
// sense encoding and the supported range of data-word widths.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    PARITY = 2'b10,
    STOP   = 2'b11
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator. Produces the parity bit that should
// accompany i_data for the requested parity sense (0 = even, 1 = odd),
// so the same block serves both the receive checker and a transmitter.
module uart_parity_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_par_typ,
  output logic             o_par_bit
);

  assign o_par_bit = (^i_data) ^ i_par_typ;

endmodule

// File: rtl/uart_rx_frame_deserializer.sv
// UART receive frame deserializer. After the start checker accepts a
// start bit, this block counts the mid-bit strobes itself, assembles the
// data word, checks the optional parity bit and the stop bit, and then
// presents the word with a one-cycle valid pulse and error flags.
module uart_rx_frame_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_det,
  input  logic                  bit_strobe,
  input  logic                  sampled_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  import uart_rx_pkg::*;

  // One extra count value so the counter can represent DATA_WIDTH
  // without wrapping inside a frame.
  localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] ONE_HOT0 = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  rx_state_t             r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_perr;
  logic                  r_serr;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic                  r_busy;

  logic [CNT_W-1:0]      w_bit_idx;
  logic [DATA_WIDTH-1:0] w_bit_mask;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  w_par_exp;

  // The bit position written by the current strobe depends on bit order;
  // a one-hot mask avoids an index wider than the word it selects into.
  assign w_bit_idx    = (MSB_FIRST != 0) ? (LAST_IDX - r_cnt) : r_cnt;
  assign w_bit_mask   = ONE_HOT0 << w_bit_idx;
  assign w_shift_next = sampled_data ? (r_shift | w_bit_mask)
                                     : (r_shift & ~w_bit_mask);

  uart_parity_calc #(
    .WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .i_data    (r_shift),
    .i_par_typ (r_par_typ),
    .o_par_bit (w_par_exp)
  );

  // Frame state machine plus the registered result stage, which publishes
  // the completed frame one clock after the stop-bit strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= PAR_EVEN;
      r_perr       <= 1'b0;
      r_serr       <= 1'b0;
      r_done       <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_data_valid <= r_done;
      if (r_done) begin
        r_p_data  <= r_shift;
        r_par_err <= r_perr;
        r_stp_err <= r_serr;
      end

      case (r_state)
        IDLE: begin
          if (start_det) begin
            r_state   <= DATA;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_par_en  <= par_en;
            r_par_typ <= par_typ;
            r_perr    <= 1'b0;
            r_serr    <= 1'b0;
            r_busy    <= 1'b1;
          end
        end

        DATA: begin
          if (bit_strobe) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LAST_IDX) begin
              r_state <= r_par_en ? PARITY : STOP;
            end
          end
        end

        PARITY: begin
          if (bit_strobe) begin
            r_perr  <= (sampled_data != w_par_exp);
            r_state <= STOP;
          end
        end

        STOP: begin
          if (bit_strobe) begin
            r_serr  <= ~sampled_data;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign p_data     = r_p_data;
  assign data_valid = r_data_valid;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_deserializer.sv
// Directed bench for the UART receive frame deserializer. One instance
// is 8-bit LSB-first, the other 7-bit MSB-first; both share stimulus.
module tb_uart_rx_frame_deserializer;

  logic CLK = 1'b0;
  logic RST;
  logic start_det;
  logic bit_strobe;
  logic sampled_data;
  logic par_en;
  logic par_typ;

  logic [7:0] p_data8;
  logic       dv8, perr8, serr8, busy8;
  logic [6:0] p_data7;
  logic       dv7, perr7, serr7, busy7;

  int checks   = 0;
  int errors   = 0;
  int dvCount8 = 0;
  int dvBefore;

  typedef struct {
    logic [8:0] bits;
    logic       pen;
    logic       ptyp;
    logic       parBit;
    logic       stopBit;
    logic [7:0] expData;
    logic       expPerr;
    logic       expSerr;
  } vec_t;

  vec_t vecs[6];

  uart_rx_frame_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(0)) dut8 (
    .CLK          (CLK),
    .RST          (RST),
    .start_det    (start_det),
    .bit_strobe   (bit_strobe),
    .sampled_data (sampled_data),
    .par_en       (par_en),
    .par_typ      (par_typ),
    .p_data       (p_data8),
    .data_valid   (dv8),
    .par_err      (perr8),
    .stp_err      (serr8),
    .busy         (busy8)
  );

  uart_rx_frame_deserializer #(.DATA_WIDTH(7), .MSB_FIRST(1)) dut7 (
    .CLK          (CLK),
    .RST          (RST),
    .start_det    (start_det),
    .bit_strobe   (bit_strobe),
    .sampled_data (sampled_data),
    .par_en       (par_en),
    .par_typ      (par_typ),
    .p_data       (p_data7),
    .data_valid   (dv7),
    .par_err      (perr7),
    .stp_err      (serr7),
    .busy         (busy7)
  );

  always #5 CLK = ~CLK;

  // Count valid pulses of the 8-bit instance, sampled shortly after each edge.
  always @(posedge CLK) begin
    #2;
    if (dv8 === 1'b1) dvCount8++;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All stimulus tasks are entered at a falling edge and leave at one.
  task automatic startFrame(input logic pen, input logic ptyp, input logic withStrobe, input logic strobeVal);
    start_det    = 1'b1;
    par_en       = pen;
    par_typ      = ptyp;
    bit_strobe   = withStrobe;
    sampled_data = strobeVal;
    @(negedge CLK);
    start_det  = 1'b0;
    bit_strobe = 1'b0;
    par_en     = ~pen;
    par_typ    = ~ptyp;
  endtask

  task automatic applyStimulus(input logic b, input int gap);
    bit_strobe   = 1'b1;
    sampled_data = b;
    @(negedge CLK);
    bit_strobe = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic sendBody(input int nbits, input logic [8:0] bits, input logic hasPar, input logic parBit);
    for (int i = 0; i < nbits; i++) applyStimulus(bits[i], 1);
    if (hasPar) applyStimulus(parBit, 1);
  endtask

  task automatic checkFrame8(input logic [7:0] expData, input logic expPerr, input logic expSerr);
    checkOutput("busy_after_stop", {15'd0, busy8}, 16'd0);
    checkOutput("dv_not_early", {15'd0, dv8}, 16'd0);
    @(negedge CLK);
    checkOutput("dv_pulse", {15'd0, dv8}, 16'd1);
    checkOutput("p_data", {8'd0, p_data8}, {8'd0, expData});
    checkOutput("par_err", {15'd0, perr8}, {15'd0, expPerr});
    checkOutput("stp_err", {15'd0, serr8}, {15'd0, expSerr});
    @(negedge CLK);
    checkOutput("dv_one_cycle", {15'd0, dv8}, 16'd0);
    checkOutput("p_data_hold", {8'd0, p_data8}, {8'd0, expData});
  endtask

  initial begin
    vecs[0] = '{bits: 9'h0A5, pen: 1'b0, ptyp: 1'b0, parBit: 1'b0, stopBit: 1'b1, expData: 8'hA5, expPerr: 1'b0, expSerr: 1'b0};
    vecs[1] = '{bits: 9'h037, pen: 1'b1, ptyp: 1'b0, parBit: 1'b1, stopBit: 1'b1, expData: 8'h37, expPerr: 1'b0, expSerr: 1'b0};
    vecs[2] = '{bits: 9'h037, pen: 1'b1, ptyp: 1'b0, parBit: 1'b0, stopBit: 1'b1, expData: 8'h37, expPerr: 1'b1, expSerr: 1'b0};
    vecs[3] = '{bits: 9'h03C, pen: 1'b0, ptyp: 1'b0, parBit: 1'b0, stopBit: 1'b0, expData: 8'h3C, expPerr: 1'b0, expSerr: 1'b1};
    vecs[4] = '{bits: 9'h05A, pen: 1'b1, ptyp: 1'b1, parBit: 1'b1, stopBit: 1'b1, expData: 8'h5A, expPerr: 1'b0, expSerr: 1'b0};
    vecs[5] = '{bits: 9'h0C3, pen: 1'b1, ptyp: 1'b1, parBit: 1'b0, stopBit: 1'b0, expData: 8'hC3, expPerr: 1'b1, expSerr: 1'b1};

    RST          = 1'b1;
    start_det    = 1'b0;
    bit_strobe   = 1'b0;
    sampled_data = 1'b1;
    par_en       = 1'b0;
    par_typ      = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_p_data", {8'd0, p_data8}, 16'd0);
    checkOutput("rst_dv", {15'd0, dv8}, 16'd0);
    checkOutput("rst_busy", {15'd0, busy8}, 16'd0);
    checkOutput("rst_flags", {14'd0, perr8, serr8}, 16'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Stray strobe in IDLE must not start anything.
    applyStimulus(1'b1, 1);
    checkOutput("idle_strobe_busy", {15'd0, busy8}, 16'd0);

    for (int v = 0; v < 6; v++) begin
      startFrame(vecs[v].pen, vecs[v].ptyp, 1'b0, 1'b0);
      checkOutput("busy_rise", {15'd0, busy8}, 16'd1);
      sendBody(8, vecs[v].bits, vecs[v].pen, vecs[v].parBit);
      applyStimulus(vecs[v].stopBit, 0);
      checkFrame8(vecs[v].expData, vecs[v].expPerr, vecs[v].expSerr);
    end

    // Reset after four data bits discards the frame immediately.
    startFrame(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1);
    RST = 1'b1;
    #1;
    checkOutput("midrst_p_data", {8'd0, p_data8}, 16'd0);
    checkOutput("midrst_flags", {14'd0, perr8, serr8}, 16'd0);
    checkOutput("midrst_busy", {15'd0, busy8}, 16'd0);
    checkOutput("midrst_dv", {15'd0, dv8}, 16'd0);
    @(negedge CLK);
    RST = 1'b0;
    dvBefore = dvCount8;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1);
    repeat (3) @(negedge CLK);
    checkOutput("midrst_no_dv", dvCount8[15:0], dvBefore[15:0]);

    // Frame 0x81 with a start_det pulse in the middle that must be ignored.
    startFrame(1'b0, 1'b0, 1'b0, 1'b0);
    sendBody(4, 9'h081, 1'b0, 1'b0);
    start_det = 1'b1;
    @(negedge CLK);
    start_det = 1'b0;
    for (int i = 4; i < 8; i++) applyStimulus(i == 7, 1);
    applyStimulus(1'b1, 0);
    checkFrame8(8'h81, 1'b0, 1'b0);

    // Back-to-back: next start in the cycle after the stop strobe, with a spurious strobe.
    dvBefore = dvCount8;
    startFrame(1'b0, 1'b0, 1'b0, 1'b0);
    sendBody(8, 9'h055, 1'b0, 1'b0);
    applyStimulus(1'b1, 0);
    startFrame(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("b2b_dv_first", {15'd0, dv8}, 16'd1);
    checkOutput("b2b_data_first", {8'd0, p_data8}, 16'h0055);
    checkOutput("b2b_busy", {15'd0, busy8}, 16'd1);
    sendBody(8, 9'h0AA, 1'b0, 1'b0);
    applyStimulus(1'b1, 0);
    checkFrame8(8'hAA, 1'b0, 1'b0);
    checkOutput("b2b_dv_count", dvCount8[15:0] - dvBefore[15:0], 16'd2);

    // 7-bit MSB-first instance, odd parity, par_en/par_typ toggled mid-frame.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      startFrame(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("w7_busy_rise", {15'd0, busy7}, 16'd1);
      sendBody(7, 9'h043, 1'b1, (k == 1));
      applyStimulus(1'b1, 0);
      checkOutput("w7_busy_fall", {15'd0, busy7}, 16'd0);
      checkOutput("w7_dv_not_early", {15'd0, dv7}, 16'd0);
      @(negedge CLK);
      checkOutput("w7_dv_pulse", {15'd0, dv7}, 16'd1);
      checkOutput("w7_p_data", {9'd0, p_data7}, 16'h0061);
      checkOutput("w7_par_err", {15'd0, perr7}, (k == 1) ? 16'd1 : 16'd0);
      checkOutput("w7_stp_err", {15'd0, serr7}, 16'd0);
      @(negedge CLK);
      checkOutput("w7_dv_one_cycle", {15'd0, dv7}, 16'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_deserializer.md
Name: uart_rx_frame_deserializer

Overview:
Parametrised UART receive deserializer that assembles one complete character frame: DATA_WIDTH data bits, an optional parity bit and one stop bit.
- Owns its own bit counter and frame state machine; the predecessor relied on an external bit_cnt.
- Checks parity and the stop bit.
- Presents the parallel word with a one-cycle valid pulse and error flags.
- Sits between the start-bit checker / data sampler and the receive output stage.

Parameters:
DATA_WIDTH, 8, number of data bits per frame; legal range 5..9.
MSB_FIRST, 0, 0 = first data bit received goes to p_data[0]; 1 = first data bit received goes to p_data[DATA_WIDTH-1].

Ports:
CLK  input  1  system clock; all state changes on rising edge.
RST  input  1  asynchronous, active-high reset.
start_det  input  1  one-cycle pulse: valid start bit accepted by the start checker.
bit_strobe  input  1  one-cycle pulse at each mid-bit sample point after the start bit.
sampled_data  input  1  majority-sampled line value; valid when bit_strobe=1.
par_en  input  1  parity bit present; captured at start_det.
par_typ  input  1  0 = even, 1 = odd; captured at start_det.
p_data  output  DATA_WIDTH  last completed frame's data word.
data_valid  output  1  one-cycle pulse: p_data, par_err and stp_err are updated.
par_err  output  1  parity mismatch for the frame flagged by data_valid.
stp_err  output  1  stop bit sampled low for the frame flagged by data_valid.
busy  output  1  high while a frame is being received (state != IDLE).

Behaviour:
- Reset (RST=1, asynchronous):
  - state = IDLE; bit counter and shift register = 0.
  - p_data = 0; data_valid = 0; par_err = 0; stp_err = 0; busy = 0.
  - Reset mid-frame discards the partial frame. No data_valid is generated for it.
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - start_det=1 -> DATA. Clear bit counter and shift register; latch par_en and par_typ.
  - bit_strobe in IDLE is ignored.
  - start_det and bit_strobe in the same cycle: start_det wins; the strobe is not counted as a data bit.
- DATA:
  - Each bit_strobe stores sampled_data at index cnt (MSB_FIRST=0) or DATA_WIDTH-1-cnt (MSB_FIRST=1), then increments cnt.
  - On the strobe with cnt = DATA_WIDTH-1: go to PARITY if latched par_en=1, else STOP.
  - Bit counter width is $clog2(DATA_WIDTH+1); it never wraps within a frame.
- PARITY:
  - On bit_strobe: expected = XOR-reduce(shift register) XOR latched par_typ.
  - Internal perr flag = (sampled_data != expected). Go to STOP.
- STOP:
  - On bit_strobe: serr = ~sampled_data. Go to IDLE.
  - On the next rising edge, registered outputs update: p_data = shift register; par_err = perr (0 if parity disabled); stp_err = serr; data_valid = 1 for exactly one cycle.
- Latency: data_valid is high in the cycle after the stop-bit strobe edge, i.e. one CLK after the strobe is sampled.
- p_data is updated on every completed frame, including errored frames. Consumers qualify it with the error flags.
- p_data, par_err and stp_err hold their values until the next data_valid.
- start_det outside IDLE is ignored; there is no re-sync mid-frame.
- par_en and par_typ changes after start_det do not affect the current frame.
- A start_det in the cycle immediately following the STOP strobe (state already IDLE) begins a new frame normally. The data_valid pulse of the previous frame still occurs.
- busy is registered: it rises the cycle after start_det and falls the cycle after the stop strobe.

Decomposition:
- Shared package uart_rx_pkg:
  - state enumeration: IDLE=2'b00, DATA=2'b01, PARITY=2'b10, STOP=2'b11.
  - parity constants: PAR_EVEN=1'b0, PAR_ODD=1'b1.
  - DATA_WIDTH bounds: 5 and 9.
- One natural sub-module: uart_parity_calc. Combinational XOR reduction of DATA_WIDTH bits plus par_typ; reusable by the TX side.

Test Plan:
- DATA_WIDTH=8, MSB_FIRST=0, par_en=0; start_det, then strobes 1,0,1,0,0,1,0,1 plus stop=1 -> p_data=8'hA5, data_valid one cycle, par_err=0, stp_err=0, busy low afterwards.
- par_en=1, par_typ=0, data 8'h37 (five ones), parity bit 1, stop 1 -> p_data=8'h37, par_err=0. Repeat with parity bit 0 -> par_err=1, p_data=8'h37.
- par_en=0, data 8'h3C, stop bit 0 -> stp_err=1, par_err=0, data_valid pulses, p_data=8'h3C.
- RST asserted after 4 data strobes of a frame -> all outputs 0 immediately, no data_valid. The next full frame of 8'h81 is received correctly.
- MSB_FIRST=1, DATA_WIDTH=7, par_en=1, par_typ=1: strobes 1,1,0,0,0,0,1 (first bit to p_data[6]), then the correct odd-parity bit, stop 1 -> p_data=7'h61, par_err=0. Toggle par_en mid-frame -> no effect.
- Back-to-back frames 8'h55 then 8'hAA, with start_det one cycle after the stop strobe and start_det coinciding with a spurious bit_strobe -> two data_valid pulses with the correct words; the spurious strobe is ignored.
